// File: rtl/fib_stream_pkg.sv
// Shared types and default sizes for the Fibonacci stream generator.
package fib_stream_pkg;

    localparam int unsigned DEF_WIDTH     = 32;
    localparam int unsigned DEF_CNT_WIDTH = 16;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/fib_stream_add.sv
// Combinational signed adder with two's-complement overflow detect.
module fib_stream_add #(
    parameter int unsigned WIDTH = 32
) (
    input  logic signed [WIDTH-1:0] a_i,
    input  logic signed [WIDTH-1:0] b_i,
    output logic signed [WIDTH-1:0] sum_o,
    output logic                    ovf_o
);

    // Overflow when operand signs agree but the sum sign differs.
    always_comb begin
        sum_o = a_i + b_i;
        ovf_o = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum_o[WIDTH-1] != a_i[WIDTH-1]);
    end

endmodule

// File: rtl/fib_stream_gen.sv
// Fibonacci-style term stream from runtime seeds and count, one term per cycle.
// Optional FIB_OVERFLOW_STOP_EN ends a run early (with _trunc) before any
// term that would have overflowed is emitted; otherwise arithmetic wraps.
module fib_stream_gen
    import fib_stream_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                    _clock,
    input  logic                    _reset,
    input  logic                    _start,
    input  logic [CNT_WIDTH-1:0]    _n,
    input  logic signed [WIDTH-1:0] _a0,
    input  logic signed [WIDTH-1:0] _b0,
    input  logic                    _ready,
    output logic                    _valid,
    output logic                    _done,
    output logic signed [WIDTH-1:0] _out0,
    output logic [CNT_WIDTH-1:0]    _out1,
    output logic                    _trunc
);

    state_e                  state_q, state_d;
    logic signed [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [CNT_WIDTH-1:0]    idx_q, idx_d, cnt_q, cnt_d;
    logic                    valid_q, valid_d, done_q, done_d;
    logic signed [WIDTH-1:0] out0_q, out0_d;
    logic [CNT_WIDTH-1:0]    out1_q, out1_d;
    logic signed [WIDTH-1:0] sum;
    logic                    end_cond;

`ifdef FIB_OVERFLOW_STOP_EN
    logic add_ovf;
    logic fa_q, fa_d, fb_q, fb_d;
    logic trunc_q, trunc_d;
`else
    logic unused_add_ovf;
`endif

    fib_stream_add #(.WIDTH(WIDTH)) u_add (
        .a_i   (a_q),
        .b_i   (b_q),
        .sum_o (sum),
`ifdef FIB_OVERFLOW_STOP_EN
        .ovf_o (add_ovf)
`else
        .ovf_o (unused_add_ovf)
`endif
    );

`ifdef FIB_OVERFLOW_STOP_EN
    assign end_cond = fa_q;
`else
    assign end_cond = 1'b0;
`endif

    // Next-state and output computation; start beats everything else.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        out0_d  = out0_q;
        out1_d  = out1_q;
        done_d  = 1'b0;
        valid_d = _ready ? 1'b0 : valid_q;
`ifdef FIB_OVERFLOW_STOP_EN
        fa_d    = fa_q;
        fb_d    = fb_q;
        trunc_d = 1'b0;
`endif
        if (_start) begin
            a_d     = _a0;
            b_d     = _b0;
            idx_d   = '0;
            cnt_d   = _n;
            valid_d = 1'b0;
            state_d = S_RUN;
`ifdef FIB_OVERFLOW_STOP_EN
            fa_d    = 1'b0;
            fb_d    = 1'b0;
`endif
        end else if (state_q == S_RUN && (_ready || !valid_q)) begin
            if (idx_q == cnt_q || end_cond) begin
                done_d  = 1'b1;
                valid_d = 1'b0;
                state_d = S_IDLE;
`ifdef FIB_OVERFLOW_STOP_EN
                trunc_d = fa_q;
`endif
            end else begin
                out0_d  = a_q;
                out1_d  = idx_q;
                valid_d = 1'b1;
                a_d     = b_q;
                b_d     = sum;
                idx_d   = idx_q + CNT_WIDTH'(1);
`ifdef FIB_OVERFLOW_STOP_EN
                fa_d    = fb_q;
                fb_d    = fa_q | fb_q | add_ovf;
`endif
            end
        end
    end

    // State register; reset is ignored when start is also high.
    always_ff @(posedge _clock) begin
        if (_reset && !_start) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            out0_q  <= '0;
            out1_q  <= '0;
`ifdef FIB_OVERFLOW_STOP_EN
            fa_q    <= 1'b0;
            fb_q    <= 1'b0;
            trunc_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            out0_q  <= out0_d;
            out1_q  <= out1_d;
`ifdef FIB_OVERFLOW_STOP_EN
            fa_q    <= fa_d;
            fb_q    <= fb_d;
            trunc_q <= trunc_d;
`endif
        end
    end

    assign _valid = valid_q;
    assign _done  = done_q;
    assign _out0  = out0_q;
    assign _out1  = out1_q;
`ifdef FIB_OVERFLOW_STOP_EN
    assign _trunc = trunc_q;
`else
    assign _trunc = 1'b0;
`endif

endmodule

// File: tb/tb_fib_stream_gen.sv
// Directed bench for fib_stream_gen: 32-bit and 8-bit instances on shared controls.
module tb_fib_stream_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, start, rdy;
    logic [15:0]        n_i;
    logic signed [31:0] a0_32, b0_32, o32;
    logic signed [7:0]  a0_8, b0_8, o8;
    logic               v32, d32, t32, v8, d8, t8;
    logic [15:0]        i32, i8;

    fib_stream_gen #(.WIDTH(32), .CNT_WIDTH(16)) dut32 (
        ._clock(clk), ._reset(rst), ._start(start), ._n(n_i), ._a0(a0_32), ._b0(b0_32),
        ._ready(rdy), ._valid(v32), ._done(d32), ._out0(o32), ._out1(i32), ._trunc(t32)
    );

    fib_stream_gen #(.WIDTH(8), .CNT_WIDTH(16)) dut8 (
        ._clock(clk), ._reset(rst), ._start(start), ._n(n_i), ._a0(a0_8), ._b0(b0_8),
        ._ready(rdy), ._valid(v8), ._done(d8), ._out0(o8), ._out1(i8), ._trunc(t8)
    );

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        int start; int rdy; int n; int e_valid; int e_out0; int e_out1; int e_done;
    } vec_t;
    vec_t vec [16];

    longint tv [64];

    task automatic chk(input string nm, input longint act, input longint exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a run and follow it to _done, checking every transfer against a model.
    task automatic stream(input bit is8, input int n, input longint a0, input longint b0,
                          input bit alt, input bit with_rst, input int exp_terms,
                          input int exp_edge, input bit exp_trunc);
        longint ea, eb, nx, po0;
        logic   pv, pr;
        logic [15:0] po1;
        int got, done_edge;
        logic   cv, cd, ct;
        longint co0;
        logic [15:0] co1;
        a0_32 = 32'(a0); b0_32 = 32'(b0);
        a0_8  = 8'(a0);  b0_8  = 8'(b0);
        n_i = 16'(n); start = 1'b1; rst = with_rst; rdy = 1'b1;
        tick();
        start = 1'b0; rst = 1'b0;
        cv = is8 ? v8 : v32;
        cd = is8 ? d8 : d32;
        chk("start_valid", longint'(cv), 0);
        chk("start_done", longint'(cd), 0);
        ea = a0; eb = b0; got = 0; done_edge = -1;
        for (int c = 0; c < 200 && done_edge < 0; c++) begin
            rdy = alt ? (c % 2 == 0) : 1'b1;
            pv  = is8 ? v8 : v32;
            po0 = is8 ? longint'(o8) : longint'(o32);
            po1 = is8 ? i8 : i32;
            pr  = rdy;
            tick();
            cv  = is8 ? v8 : v32;
            cd  = is8 ? d8 : d32;
            ct  = is8 ? t8 : t32;
            co0 = is8 ? longint'(o8) : longint'(o32);
            co1 = is8 ? i8 : i32;
            if (pv && pr) begin
                chk("term_value", po0, ea);
                chk("term_index", longint'(po1), got);
                if (got < 64) tv[got] = po0;
                nx = ea + eb;
                if (is8) nx = longint'($signed(nx[7:0]));
                else     nx = longint'($signed(nx[31:0]));
                ea = eb; eb = nx;
                got++;
            end
            if (pv && !pr) begin
                chk("hold_valid", longint'(cv), 1);
                chk("hold_out0", co0, po0);
                chk("hold_out1", longint'(co1), longint'(po1));
            end
            if (cd) begin
                done_edge = c + 1;
                chk("done_no_valid", longint'(cv), 0);
                chk("done_trunc", longint'(ct), longint'(exp_trunc));
            end
        end
        chk("term_count", got, exp_terms);
        chk("done_edge", done_edge, exp_edge);
        rdy = 1'b1;
        tick();
        cd = is8 ? d8 : d32;
        chk("done_pulse_len", longint'(cd), 0);
    endtask

    initial begin
        bit seen_v, seen_d;
        vec[0]  = '{1, 1, 10, 0,  0, 0, 0};
        vec[1]  = '{0, 1, 10, 1,  0, 0, 0};
        vec[2]  = '{0, 1, 10, 1,  1, 1, 0};
        vec[3]  = '{0, 1, 10, 1,  1, 2, 0};
        vec[4]  = '{0, 1, 10, 1,  2, 3, 0};
        vec[5]  = '{0, 1, 10, 1,  3, 4, 0};
        vec[6]  = '{0, 1, 10, 1,  5, 5, 0};
        vec[7]  = '{0, 1, 10, 1,  8, 6, 0};
        vec[8]  = '{0, 1, 10, 1, 13, 7, 0};
        vec[9]  = '{0, 1, 10, 1, 21, 8, 0};
        vec[10] = '{0, 1, 10, 1, 34, 9, 0};
        vec[11] = '{0, 1, 10, 0,  0, 0, 1};
        vec[12] = '{0, 1, 10, 0,  0, 0, 0};
        vec[13] = '{1, 1,  0, 0,  0, 0, 0};
        vec[14] = '{0, 1,  0, 0,  0, 0, 1};
        vec[15] = '{0, 1,  0, 0,  0, 0, 0};

        rst = 1'b1; start = 1'b0; rdy = 1'b1; n_i = '0;
        a0_32 = '0; b0_32 = '0; a0_8 = '0; b0_8 = '0;
        tick(); tick();
        chk("rst_valid32", longint'(v32), 0);
        chk("rst_done32", longint'(d32), 0);
        chk("rst_trunc32", longint'(t32), 0);
        chk("rst_out0_32", longint'(o32), 0);
        chk("rst_out1_32", longint'(i32), 0);
        chk("rst_valid8", longint'(v8), 0);
        chk("rst_out0_8", longint'(o8), 0);
        rst = 1'b0;
        tick();

        // Basic 10-term run and zero-count run, cycle by cycle.
        a0_32 = 32'sd0; b0_32 = 32'sd1; a0_8 = 8'sd0; b0_8 = 8'sd1;
        for (int k = 0; k < 16; k++) begin
            start = vec[k].start[0];
            rdy   = vec[k].rdy[0];
            n_i   = 16'(vec[k].n);
            tick();
            chk($sformatf("vec%0d_valid", k), longint'(v32), vec[k].e_valid);
            chk($sformatf("vec%0d_done", k), longint'(d32), vec[k].e_done);
            if (vec[k].e_valid != 0) begin
                chk($sformatf("vec%0d_out0", k), longint'(o32), vec[k].e_out0);
                chk($sformatf("vec%0d_out1", k), longint'(i32), vec[k].e_out1);
            end
            if (vec[k].e_done != 0) chk($sformatf("vec%0d_trunc", k), longint'(t32), 0);
        end
        start = 1'b0;

        // Backpressure: ready alternating, 10 low-ready cycles while valid.
        stream(1'b0, 10, 0, 1, 1'b1, 1'b0, 10, 21, 1'b0);

        // 8-bit long run: overflow stop or wrap depending on build.
`ifdef FIB_OVERFLOW_STOP_EN
        stream(1'b1, 20, 0, 1, 1'b0, 1'b0, 12, 13, 1'b1);
        chk("ovf_last_term", tv[11], 89);
`else
        stream(1'b1, 20, 0, 1, 1'b0, 1'b0, 20, 21, 1'b0);
        chk("wrap_term12", tv[12], -112);
        chk("wrap_term13", tv[13], -23);
`endif

        // Reset aborts a run at term 4 with no done.
        a0_32 = 32'sd0; b0_32 = 32'sd1; n_i = 16'd10; rdy = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        chk("abort_pre_idx", longint'(i32), 4);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("abort_valid", longint'(v32), 0);
        seen_v = 1'b0; seen_d = 1'b0;
        for (int k = 0; k < 14; k++) begin
            tick();
            if (v32) seen_v = 1'b1;
            if (d32) seen_d = 1'b1;
        end
        chk("abort_no_valid", longint'(seen_v), 0);
        chk("abort_no_done", longint'(seen_d), 0);

        // Restart mid-run from new seeds.
        a0_32 = 32'sd0; b0_32 = 32'sd1; n_i = 16'd10;
        start = 1'b1; tick(); start = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        chk("restart_pre_idx", longint'(i32), 3);
        stream(1'b0, 3, 5, 7, 1'b0, 1'b0, 3, 4, 1'b0);
        chk("restart_term2", tv[2], 12);

        // Start and reset together: start wins.
        stream(1'b0, 10, 0, 1, 1'b0, 1'b1, 10, 11, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
